// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// ALU operations, datapath mux selects, FSM states and instruction classes.
package mips_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned ESTADO_W = 5;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_XOR = 6'h26;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_OP_W-1:0] ALU_NOP = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_CMP = 3'b111;

  localparam logic       IORD_PC      = 1'b0;
  localparam logic       IORD_ALUOUT  = 1'b1;
  localparam logic       REGDST_RT    = 1'b0;
  localparam logic       REGDST_RD    = 1'b1;
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_A       = 1'b1;
  localparam logic [1:0] M2R_ALUOUT   = 2'b00;
  localparam logic [1:0] M2R_MDR      = 2'b01;
  localparam logic [1:0] M2R_LT       = 2'b10;
  localparam logic [1:0] M2R_LUI      = 2'b11;
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_4       = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [ESTADO_W-1:0] {
    RESET      = 5'd0,
    FETCH      = 5'd1,
    FETCH_WAIT = 5'd2,
    DECODE     = 5'd3,
    R_EXEC     = 5'd4,
    R_WB       = 5'd5,
    ADDI_EXEC  = 5'd6,
    ADDI_WB    = 5'd7,
    MEM_ADDR   = 5'd8,
    LW_READ    = 5'd9,
    LW_WAIT    = 5'd10,
    LW_WB      = 5'd11,
    SW_WRITE   = 5'd12,
    BRANCH     = 5'd13,
    JUMP       = 5'd14,
    LUI_WB     = 5'd15,
    ILLEGAL    = 5'd16
  } estado_t;

  typedef enum logic [3:0] {
    CL_R, CL_ADDI, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_LUI, CL_ILLEGAL
  } classe_t;

endpackage

// File: rtl/classe_instr.sv
// Combinational instruction classifier: Opcode/Funct to instruction class,
// plus the ALU operation and slt flag used by R-type execute/write-back.
module classe_instr
  import mips_pkg::*;
(
  input  logic [OP_W-1:0]     i_opcode,
  input  logic [OP_W-1:0]     i_funct,
  output classe_t             o_classe,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_slt
);

  always_comb begin
    o_classe = CL_ILLEGAL;
    o_alu_op = ALU_ADD;
    o_slt    = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_classe = CL_R;
        case (i_funct)
          FN_ADD:  o_alu_op = ALU_ADD;
          FN_SUB:  o_alu_op = ALU_SUB;
          FN_AND:  o_alu_op = ALU_AND;
          FN_XOR:  o_alu_op = ALU_XOR;
          FN_SLT: begin
            o_alu_op = ALU_CMP;
            o_slt    = 1'b1;
          end
          default: o_classe = CL_ILLEGAL;
        endcase
      end
      OP_ADDI: o_classe = CL_ADDI;
      OP_LW:   o_classe = CL_LW;
      OP_SW:   o_classe = CL_SW;
      OP_BEQ:  o_classe = CL_BEQ;
      OP_BNE:  o_classe = CL_BNE;
      OP_J:    o_classe = CL_J;
      OP_LUI:  o_classe = CL_LUI;
      default: o_classe = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle MIPS control FSM: sequences fetch, decode, execute, memory and
// write-back, driving every datapath enable and mux select.
module unidade_controle
  import mips_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic [OP_W-1:0]     Opcode,
  input  logic [OP_W-1:0]     Funct,
  input  logic                Zero,
  output logic                PC_Escreve,
  output logic                PC_Reset,
  output logic                IorD,
  output logic                Mem_Wr,
  output logic                IR_Load,
  output logic                MDR_Load,
  output logic                AB_Load,
  output logic                ALUOut_Load,
  output logic                Reg_Wr,
  output logic                Reg_Dst,
  output logic [1:0]          Mem_To_Reg,
  output logic                ALU_SrcA,
  output logic [1:0]          ALU_SrcB,
  output logic [ALU_OP_W-1:0] ALU_Op,
  output logic [1:0]          PC_Source,
  output logic                Illegal,
  output logic [ESTADO_W-1:0] Estado
);

  estado_t                r_estado;
  estado_t                w_proximo;
  classe_t                w_classe;
  logic [ALU_OP_W-1:0]    w_r_alu_op;
  logic                   w_slt;

  classe_instr u_classe (
    .i_opcode (Opcode),
    .i_funct  (Funct),
    .o_classe (w_classe),
    .o_alu_op (w_r_alu_op),
    .o_slt    (w_slt)
  );

  always_ff @(posedge Clk) begin
    if (Reset) r_estado <= RESET;
    else       r_estado <= w_proximo;
  end

  assign Estado = ESTADO_W'(r_estado);

  // Next state plus state-decoded outputs; PC_Escreve in BRANCH also sees Zero.
  always_comb begin
    w_proximo   = FETCH;
    PC_Escreve  = 1'b0;
    PC_Reset    = 1'b0;
    IorD        = IORD_PC;
    Mem_Wr      = 1'b0;
    IR_Load     = 1'b0;
    MDR_Load    = 1'b0;
    AB_Load     = 1'b0;
    ALUOut_Load = 1'b0;
    Reg_Wr      = 1'b0;
    Reg_Dst     = REGDST_RT;
    Mem_To_Reg  = M2R_ALUOUT;
    ALU_SrcA    = SRCA_PC;
    ALU_SrcB    = SRCB_B;
    ALU_Op      = ALU_NOP;
    PC_Source   = PCSRC_ALU;
    Illegal     = 1'b0;
    case (r_estado)
      RESET: PC_Reset = 1'b1;
      FETCH: begin
        IorD      = IORD_PC;
        w_proximo = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        IR_Load    = 1'b1;
        ALU_SrcA   = SRCA_PC;
        ALU_SrcB   = SRCB_4;
        ALU_Op     = ALU_ADD;
        PC_Source  = PCSRC_ALU;
        PC_Escreve = 1'b1;
        w_proximo  = DECODE;
      end
      DECODE: begin
        AB_Load     = 1'b1;
        ALU_SrcA    = SRCA_PC;
        ALU_SrcB    = SRCB_IMM_SH2;
        ALU_Op      = ALU_ADD;
        ALUOut_Load = 1'b1;
        case (w_classe)
          CL_R:          w_proximo = R_EXEC;
          CL_ADDI:       w_proximo = ADDI_EXEC;
          CL_LW, CL_SW:  w_proximo = MEM_ADDR;
          CL_BEQ, CL_BNE: w_proximo = BRANCH;
          CL_J:          w_proximo = JUMP;
          CL_LUI:        w_proximo = LUI_WB;
          default:       w_proximo = ILLEGAL;
        endcase
      end
      R_EXEC: begin
        ALU_SrcA    = SRCA_A;
        ALU_SrcB    = SRCB_B;
        ALU_Op      = w_r_alu_op;
        ALUOut_Load = 1'b1;
        w_proximo   = R_WB;
      end
      R_WB: begin
        // ALU inputs stay as in R_EXEC so the slt Lt flag is still valid.
        ALU_SrcA   = SRCA_A;
        ALU_SrcB   = SRCB_B;
        ALU_Op     = w_r_alu_op;
        Reg_Wr     = 1'b1;
        Reg_Dst    = REGDST_RD;
        Mem_To_Reg = w_slt ? M2R_LT : M2R_ALUOUT;
      end
      ADDI_EXEC: begin
        ALU_SrcA    = SRCA_A;
        ALU_SrcB    = SRCB_IMM;
        ALU_Op      = ALU_ADD;
        ALUOut_Load = 1'b1;
        w_proximo   = ADDI_WB;
      end
      ADDI_WB: begin
        Reg_Wr     = 1'b1;
        Reg_Dst    = REGDST_RT;
        Mem_To_Reg = M2R_ALUOUT;
      end
      MEM_ADDR: begin
        ALU_SrcA    = SRCA_A;
        ALU_SrcB    = SRCB_IMM;
        ALU_Op      = ALU_ADD;
        ALUOut_Load = 1'b1;
        w_proximo   = (w_classe == CL_LW) ? LW_READ : SW_WRITE;
      end
      LW_READ: begin
        IorD      = IORD_ALUOUT;
        w_proximo = LW_WAIT;
      end
      LW_WAIT: begin
        IorD      = IORD_ALUOUT;
        MDR_Load  = 1'b1;
        w_proximo = LW_WB;
      end
      LW_WB: begin
        Reg_Wr     = 1'b1;
        Reg_Dst    = REGDST_RT;
        Mem_To_Reg = M2R_MDR;
      end
      SW_WRITE: begin
        IorD   = IORD_ALUOUT;
        Mem_Wr = 1'b1;
      end
      BRANCH: begin
        ALU_SrcA   = SRCA_A;
        ALU_SrcB   = SRCB_B;
        ALU_Op     = ALU_SUB;
        PC_Source  = PCSRC_ALUOUT;
        PC_Escreve = (w_classe == CL_BEQ) ? Zero : !Zero;
      end
      JUMP: begin
        PC_Source  = PCSRC_JUMP;
        PC_Escreve = 1'b1;
      end
      LUI_WB: begin
        Reg_Wr     = 1'b1;
        Reg_Dst    = REGDST_RT;
        Mem_To_Reg = M2R_LUI;
      end
      ILLEGAL: Illegal = 1'b1;
      default: w_proximo = RESET;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: per-cycle control vectors compared
// against an instruction-level model of the multicycle sequence.
module tb_unidade_controle;

  localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                 K_BNE = 5, K_J = 6, K_LUI = 7, K_ILL = 8;
  localparam logic [20:0] RST_VEC = 21'h080000;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] Opcode, Funct;
  logic       Zero;
  logic       PC_Escreve, PC_Reset, IorD, Mem_Wr, IR_Load, MDR_Load, AB_Load;
  logic       ALUOut_Load, Reg_Wr, Reg_Dst, ALU_SrcA, Illegal;
  logic [1:0] Mem_To_Reg, ALU_SrcB, PC_Source;
  logic [2:0] ALU_Op;
  logic [4:0] Estado;

  int checks = 0;
  int errors = 0;

  unidade_controle dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PC_Escreve(PC_Escreve), .PC_Reset(PC_Reset), .IorD(IorD), .Mem_Wr(Mem_Wr),
    .IR_Load(IR_Load), .MDR_Load(MDR_Load), .AB_Load(AB_Load),
    .ALUOut_Load(ALUOut_Load), .Reg_Wr(Reg_Wr), .Reg_Dst(Reg_Dst),
    .Mem_To_Reg(Mem_To_Reg), .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB),
    .ALU_Op(ALU_Op), .PC_Source(PC_Source), .Illegal(Illegal), .Estado(Estado)
  );

  always #5 Clk = ~Clk;

  function automatic logic [20:0] obs();
    return {PC_Escreve, PC_Reset, IorD, Mem_Wr, IR_Load, MDR_Load, AB_Load,
            ALUOut_Load, Reg_Wr, Reg_Dst, Mem_To_Reg, ALU_SrcA, ALU_SrcB,
            ALU_Op, PC_Source, Illegal};
  endfunction

  function automatic int kind_of(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'h00: return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                     fn == 6'h26 || fn == 6'h2A) ? K_R : K_ILL;
      6'h08: return K_ADDI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h02: return K_J;
      6'h0F: return K_LUI;
      default: return K_ILL;
    endcase
  endfunction

  function automatic int cycles_of(int kd);
    if (kd == K_LW) return 7;
    if (kd == K_R || kd == K_ADDI || kd == K_SW) return 5;
    return 4;
  endfunction

  function automatic logic [2:0] r_alu(logic [5:0] fn);
    case (fn)
      6'h22: return 3'b010;
      6'h24: return 3'b011;
      6'h26: return 3'b110;
      6'h2A: return 3'b111;
      default: return 3'b001;
    endcase
  endfunction

  // Expected control vector for cycle k (0 = fetch) of an instruction.
  function automatic logic [20:0] exp_ctl(logic [5:0] op, logic [5:0] fn,
                                          int k, logic z);
    int kd = kind_of(op, fn);
    logic pce = 0, iord = 0, mw = 0, irl = 0, mdr = 0, ab = 0, alo = 0;
    logic rw = 0, rd = 0, sa = 0, ill = 0;
    logic [1:0] m2r = 0, sb = 0, ps = 0;
    logic [2:0] aop = 0;
    if (k == 1) begin
      irl = 1; sb = 2'b01; aop = 3'b001; pce = 1;
    end else if (k == 2) begin
      ab = 1; sb = 2'b11; aop = 3'b001; alo = 1;
    end else if (k >= 3) begin
      case (kd)
        K_R: begin
          sa = 1; aop = r_alu(fn);
          if (k == 3) alo = 1;
          else begin rw = 1; rd = 1; m2r = (fn == 6'h2A) ? 2'b10 : 2'b00; end
        end
        K_ADDI, K_LW, K_SW: begin
          if (k == 3) begin sa = 1; sb = 2'b10; aop = 3'b001; alo = 1; end
          else if (kd == K_ADDI) rw = 1;
          else if (kd == K_SW) begin iord = 1; mw = 1; end
          else if (k == 4) iord = 1;
          else if (k == 5) begin iord = 1; mdr = 1; end
          else begin rw = 1; m2r = 2'b01; end
        end
        K_BEQ, K_BNE: begin
          sa = 1; aop = 3'b010; ps = 2'b01;
          pce = (kd == K_BEQ) ? z : ~z;
        end
        K_J: begin ps = 2'b10; pce = 1; end
        K_LUI: begin rw = 1; m2r = 2'b11; end
        default: ill = 1;
      endcase
    end
    return {pce, 1'b0, iord, mw, irl, mdr, ab, alo, rw, rd, m2r, sa, sb,
            aop, ps, ill};
  endfunction

  // Runs up to ncut cycles of one instruction starting at its FETCH cycle.
  // zmode: 0/1 forces Zero, 2 randomizes it each cycle.
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, int zmode, int ncut);
    int n = cycles_of(kind_of(op, fn));
    logic [20:0] e;
    if (ncut < n) n = ncut;
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      Opcode = op; Funct = fn;
      Zero = (zmode == 2) ? 1'($urandom_range(1)) : 1'(zmode);
      #1;
      e = exp_ctl(op, fn, k, Zero);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL ctl op=%h fn=%h k=%0d z=%b got=%b exp=%b",
                 op, fn, k, Zero, obs(), e);
      end
      checks++;
      if (Estado === 5'd0) begin
        errors++;
        $display("FAIL estado_not_reset op=%h k=%0d got=%0d exp=nonzero",
                 op, k, Estado);
      end
    end
  endtask

  // Assert Reset just before the edge leaving cycle cut-1, check RESET, release.
  task automatic reset_mid(logic [5:0] op, logic [5:0] fn, int cut);
    run_instr(op, fn, 2, cut);
    Reset = 1'b1;
    @(negedge Clk); #1;
    checks++;
    if (obs() !== RST_VEC || Estado !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset op=%h cut=%0d got=%b/%0d exp=%b/0",
               op, cut, obs(), Estado, RST_VEC);
    end
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Opcode = 6'h00; Funct = 6'h20; Zero = 1'b0;
    repeat (3) begin
      @(negedge Clk); #1;
      checks++;
      if (obs() !== RST_VEC || Estado !== 5'd0) begin
        errors++;
        $display("FAIL reset_hold got=%b/%0d exp=%b/0", obs(), Estado, RST_VEC);
      end
    end
    Reset = 1'b0;
  endtask

  task automatic test_rtype();
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h26, 6'h2A};
    foreach (fns[i]) run_instr(6'h00, fns[i], 2, 99);
  endtask

  task automatic test_lw_sw_addi();
    run_instr(6'h23, 6'($urandom), 2, 99);
    run_instr(6'h2B, 6'($urandom), 2, 99);
    run_instr(6'h08, 6'($urandom), 2, 99);
  endtask

  task automatic test_branch();
    run_instr(6'h04, 6'h00, 1, 99);
    run_instr(6'h05, 6'h00, 1, 99);
    run_instr(6'h04, 6'h00, 0, 99);
    run_instr(6'h05, 6'h00, 0, 99);
  endtask

  task automatic test_sw_reset();
    reset_mid(6'h2B, 6'h00, 4);
    run_instr(6'h23, 6'h00, 2, 99);
    reset_mid(6'h23, 6'h00, 6);
    run_instr(6'h00, 6'h2A, 2, 99);
  endtask

  task automatic test_illegal_jump();
    run_instr(6'h3F, 6'h20, 2, 99);
    run_instr(6'h00, 6'h21, 2, 99);
    run_instr(6'h02, 6'h00, 2, 99);
    run_instr(6'h0F, 6'h00, 2, 99);
  endtask

  task automatic test_random();
    logic [5:0] ops [8] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h0F};
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h26, 6'h2A};
    logic [5:0] op, fn;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(5) == 0) ? 6'($urandom) : ops[$urandom_range(7)];
      fn = ($urandom_range(4) == 0) ? 6'($urandom) : fns[$urandom_range(4)];
      if ($urandom_range(9) == 0)
        reset_mid(op, fn, 1 + $urandom_range(cycles_of(kind_of(op, fn)) - 1));
      else
        run_instr(op, fn, 2, 99);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_sw_addi();
    test_branch();
    test_sw_reset();
    test_illegal_jump();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle MIPS control unit: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and write-back over the existing datapath (PC, memory address mux, memory, instruction register, register bank, ALU). It takes the opcode and funct fields from the instruction register and the ALU Zero flag. It drives every load, write and select line of the datapath, one instruction at a time, with 4–7 cycles per instruction.

## Interface
- No parameters; all encodings are fixed in `mips_pkg`.
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `Opcode` in 6: `Instr31_26`.
- `Funct` in 6: `Instr15_0[5:0]`.
- `Zero` in 1: ALU zero flag, valid in the BRANCH cycle.
- `PC_Escreve` out 1: PC load enable.
- `PC_Reset` out 1: PC and IR reset.
- `IorD` out 1: memory-address mux select; 0 = PC, 1 = ALUOut.
- `Mem_Wr` out 1: memory write.
- `IR_Load` out 1: instruction register load.
- `MDR_Load` out 1: memory data register load.
- `AB_Load` out 1: A/B register load.
- `ALUOut_Load` out 1: ALUOut register load.
- `Reg_Wr` out 1: register bank write.
- `Reg_Dst` out 1: write-register select; 0 = rt, 1 = rd.
- `Mem_To_Reg` out 2: write-data select; 00 = ALUOut, 01 = MDR, 10 = {31'b0, Lt}, 11 = {imm16, 16'b0}.
- `ALU_SrcA` out 1: ALU A input; 0 = PC, 1 = A.
- `ALU_SrcB` out 2: ALU B input; 00 = B, 01 = 4, 10 = signext(imm), 11 = signext(imm)<<2.
- `ALU_Op` out 3: 001 = ADD, 010 = SUB, 011 = AND, 110 = XOR, 111 = CMP.
- `PC_Source` out 2: PC input; 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], Instr25_0, 2'b00}.
- `Illegal` out 1: one-cycle pulse for an unsupported instruction.
- `Estado` out 5: current state, for debug.

## Operation
- **Supported instructions:**
  - R-type (Opcode 0x00): add 0x20, sub 0x22, and 0x24, xor 0x26, slt 0x2A.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, lui 0x0F.
- **Output defaults:** every output is 0 unless listed for the current state.
- **States and transitions:**
  - RESET: PC_Reset=1. → FETCH.
  - FETCH: IorD=0. The memory address is applied. → FETCH_WAIT.
  - FETCH_WAIT: IR_Load=1, ALU_SrcA=0, ALU_SrcB=01, ALU_Op=ADD, PC_Source=00, PC_Escreve=1. → DECODE.
  - DECODE: AB_Load=1, ALU_SrcA=0, ALU_SrcB=11, ALU_Op=ADD, ALUOut_Load=1. Branches on the decoded class.
  - R_EXEC: ALU_SrcA=1, ALU_SrcB=00, ALU_Op from Funct (slt uses CMP), ALUOut_Load=1. → R_WB.
  - R_WB: Reg_Wr=1, Reg_Dst=1, Mem_To_Reg=00, or 10 for slt; ALU inputs held as in R_EXEC so Lt stays valid. → FETCH.
  - ADDI_EXEC: ALU_SrcA=1, ALU_SrcB=10, ALU_Op=ADD, ALUOut_Load=1. → ADDI_WB.
  - ADDI_WB: Reg_Wr=1, Reg_Dst=0, Mem_To_Reg=00. → FETCH.
  - MEM_ADDR: ALU_SrcA=1, ALU_SrcB=10, ALU_Op=ADD, ALUOut_Load=1. → LW_READ for lw, SW_WRITE for sw.
  - LW_READ: IorD=1. → LW_WAIT.
  - LW_WAIT: IorD=1, MDR_Load=1. → LW_WB.
  - LW_WB: Reg_Wr=1, Reg_Dst=0, Mem_To_Reg=01. → FETCH.
  - SW_WRITE: IorD=1, Mem_Wr=1. → FETCH.
  - BRANCH: ALU_SrcA=1, ALU_SrcB=00, ALU_Op=SUB, PC_Source=01. PC_Escreve=Zero for beq and !Zero for bne; this is the only Mealy output. → FETCH.
  - JUMP: PC_Source=10, PC_Escreve=1. → FETCH.
  - LUI_WB: Reg_Wr=1, Reg_Dst=0, Mem_To_Reg=11. → FETCH.
  - ILLEGAL: Illegal=1. → FETCH. No write of any kind occurs.
- **Illegal decode:** an unknown opcode, or an unknown funct with Opcode 0, goes to ILLEGAL.

## Timing
- **Reset:** `Reset`=1 at an edge forces RESET on the next cycle, from any state, including mid-lw or mid-sw. A pending Mem_Wr or Reg_Wr is dropped.
  - While in RESET, all outputs are 0 except PC_Reset=1.
  - The first FETCH is one cycle after `Reset` deasserts.
- **Memory latency:** memory output is valid one cycle after the address is applied. This is why FETCH_WAIT and LW_WAIT exist.
- **Cycles per instruction:**
  - R-type, addi, sw: 5.
  - lw: 7.
  - beq, bne, j, lui, illegal: 4.
- **Decode timing:** Opcode and Funct are sampled in DECODE; the IR is stable from then until the next FETCH_WAIT.
- **Branch:** Zero is sampled combinationally in BRANCH; the PC updates on the edge that leaves BRANCH.

## Structure
- **`mips_pkg`:**
  - Opcode and funct localparams.
  - ALU_Op encodings.
  - Mux-select encodings.
  - `estado_t` enum, 5 bits, with RESET=0.
- **Sub-module `classe_instr`:** combinational Opcode/Funct → instruction-class enum plus ALU_Op for R-type.
- **`unidade_controle`:** holds the state register and the output decode.

## Test plan
- Reset held 3 cycles, then released → PC_Reset=1 while in RESET, FETCH on the first cycle after release; Estado sequence 0 → FETCH → FETCH_WAIT.
- Opcode 0x00, Funct 0x20 → 5-cycle sequence; Reg_Wr=1 only in R_WB, with Reg_Dst=1; IR_Load and PC_Escreve high only in FETCH_WAIT.
- Opcode 0x23 → 7 cycles; IorD=1 in LW_READ and LW_WAIT; MDR_Load in LW_WAIT; Mem_To_Reg=01 with Reg_Wr in LW_WB.
- Opcode 0x04: with Zero=1 → PC_Escreve=1 and PC_Source=01 in BRANCH. Opcode 0x05 with Zero=1 → PC_Escreve=0. Both take 4 cycles.
- Opcode 0x2B with Reset asserted during MEM_ADDR → next state RESET and Mem_Wr never asserted.
- Opcode 0x3F → Illegal pulses exactly one cycle, no write enables asserted, then FETCH. Opcode 0x02 → PC_Source=10 with PC_Escreve=1 in JUMP.
